// File: rtl/ic_req_flit_fifo.sv
// Packet-aware flit buffer between the I-cache request upload serializer and the
// ring injection port; flits are presented only once a complete packet is stored.
module ic_req_flit_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   flit_in,
  input  logic [1:0]    ctrl_in,
  input  logic          v_flit_in,
  output logic          req_fifo_rdy,
  output logic [15:0]   flit_out,
  output logic [1:0]    ctrl_out,
  output logic          v_flit_out,
  input  logic          flit_out_ack,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   pkt_cnt
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [1:0]  CTRL_INV  = 2'b00;
  localparam logic [1:0]  CTRL_TAIL = 2'b11;

  logic [15:0]   flit_mem_q [DEPTH];
  logic [1:0]    ctrl_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   pkt_cnt_q, pkt_cnt_d;

  logic          wr_en, rd_en, wr_tail, rd_tail;
  logic [1:0]    head_ctrl;

  // Status decodes come from registered state only, so ready never sees the same-cycle ack.
  assign req_fifo_rdy = (count_q < DEPTH_C);
  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign pkt_cnt      = pkt_cnt_q;
  assign v_flit_out   = !fifo_empty && (pkt_cnt_q != '0);
  assign head_ctrl    = ctrl_mem_q[rd_ptr_q];
  assign flit_out     = v_flit_out ? flit_mem_q[rd_ptr_q] : 16'h0000;
  assign ctrl_out     = v_flit_out ? head_ctrl : 2'b00;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_en     = v_flit_in && req_fifo_rdy && (ctrl_in != CTRL_INV);
    rd_en     = v_flit_out && flit_out_ack;
    wr_tail   = wr_en && (ctrl_in == CTRL_TAIL);
    rd_tail   = rd_en && (head_ctrl == CTRL_TAIL);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case ({wr_tail, rd_tail})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      flit_mem_q[wr_ptr_q] <= flit_in;
      ctrl_mem_q[wr_ptr_q] <= ctrl_in;
    end
  end

endmodule
